// File: rtl/pc_sequencer_pkg.sv
// pc_sequencer_pkg
//   Shared types and constants for the fetch-PC sequencer.
//   - word_t        : 32-bit architectural word
//   - pcs_state_e   : sequencer state encoding (HOLD / RUN / EXC, 2-bit)
//   - npc_src_e     : which source the next-PC mux selected
//   - RESET_PC_DEF / EXC_VEC_DEF : default reset PC and exception vector
//   - helper functions to classify mux sources and detect misaligned words
package pc_sequencer_pkg;

  localparam int DATA_W = 32;

  typedef logic [DATA_W-1:0] word_t;

  localparam word_t RESET_PC_DEF = 32'h0000_3000;
  localparam word_t EXC_VEC_DEF  = 32'h0000_4180;

  typedef enum logic [1:0] {
    PCS_HOLD = 2'b00,
    PCS_RUN  = 2'b01,
    PCS_EXC  = 2'b10
  } pcs_state_e;

  typedef enum logic [2:0] {
    SRC_SEQ  = 3'd0,
    SRC_JR   = 3'd1,
    SRC_J    = 3'd2,
    SRC_BR   = 3'd3,
    SRC_ERET = 3'd4,
    SRC_EXC  = 3'd5
  } npc_src_e;

  // Redirects resolved in ID; these are the ones that can be buffered under stall.
  function automatic logic is_ctl_redirect(input npc_src_e s);
    return (s == SRC_BR) || (s == SRC_J) || (s == SRC_JR);
  endfunction

  // Redirects originating in CP0; these bypass stall and flush the buffer.
  function automatic logic is_cp0_redirect(input npc_src_e s);
    return (s == SRC_EXC) || (s == SRC_ERET);
  endfunction

  function automatic logic word_misal(input word_t a);
    return a[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/pc_sequencer_nextpc.sv
// pc_sequencer_nextpc
//   Combinational next-PC mux with fixed priority:
//     exc_req > eret > br_taken > jump > jump_r > sequential pc4
//   Ports:
//     pc4      in  32  sequential successor of the current pc
//     exc_req  in  1   exception/interrupt request, target exc_vec
//     exc_vec  in  32  exception handler entry address
//     eret     in  1   return from exception, target epc
//     epc      in  32  CP0 EPC
//     br_taken in  1   branch taken, target br_addr
//     br_addr  in  32
//     jump     in  1   j/jal, target j_addr
//     j_addr   in  32
//     jump_r   in  1   jr/jalr, target jr_addr
//     jr_addr  in  32
//     src      out 3   selected source
//     target   out 32  selected next-PC
module pc_sequencer_nextpc
  import pc_sequencer_pkg::*;
(
  input  word_t    pc4,
  input  logic     exc_req,
  input  word_t    exc_vec,
  input  logic     eret,
  input  word_t    epc,
  input  logic     br_taken,
  input  word_t    br_addr,
  input  logic     jump,
  input  word_t    j_addr,
  input  logic     jump_r,
  input  word_t    jr_addr,
  output npc_src_e src,
  output word_t    target
);

  always_comb begin
    src    = SRC_SEQ;
    target = pc4;
    if (exc_req) begin
      src    = SRC_EXC;
      target = exc_vec;
    end else if (eret) begin
      src    = SRC_ERET;
      target = epc;
    end else if (br_taken) begin
      src    = SRC_BR;
      target = br_addr;
    end else if (jump) begin
      src    = SRC_J;
      target = j_addr;
    end else if (jump_r) begin
      src    = SRC_JR;
      target = jr_addr;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Owns the architectural fetch PC. Selects the next PC among exception
//   entry, eret, branch, jump, jump-register and sequential pc+4; holds the
//   PC under stall while buffering an ID-stage redirect raised during the
//   stall; inserts a fetch bubble after reset release and on exception entry.
//   Parameters:
//     RESET_PC  PC loaded while reset is asserted
//     EXC_VEC   exception handler entry address
//   Ports:
//     clk       in  1   rising-edge clock
//     reset_n   in  1   asynchronous active-low reset
//     stall     in  1   hold pc when 1
//     br_taken  in  1   / br_addr  in 32
//     jump      in  1   / j_addr   in 32
//     jump_r    in  1   / jr_addr  in 32
//     exc_req   in  1   CP0 exception/interrupt request
//     eret      in  1   / epc      in 32
//     pc        out 32  current fetch PC (register)
//     pc4       out 32  pc + 4 (combinational, wraps)
//     fetch_vld out 1   instruction at pc is to be issued (register)
//     pc_misal  out 1   pc[1:0] != 0 (register, tracks pc)
//     pend_vld  out 1   a buffered redirect is held
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter word_t RESET_PC = RESET_PC_DEF,
  parameter word_t EXC_VEC  = EXC_VEC_DEF
) (
  input  logic  clk,
  input  logic  reset_n,
  input  logic  stall,
  input  logic  br_taken,
  input  word_t br_addr,
  input  logic  jump,
  input  word_t j_addr,
  input  logic  jump_r,
  input  word_t jr_addr,
  input  logic  exc_req,
  input  logic  eret,
  input  word_t epc,
  output word_t pc,
  output word_t pc4,
  output logic  fetch_vld,
  output logic  pc_misal,
  output logic  pend_vld
);

  pcs_state_e state;
  pcs_state_e state_nxt;
  npc_src_e   npc_src;
  word_t      npc_tgt;
  word_t      pc_nxt;
  word_t      pend_addr;
  logic       pend_vld_nxt;
  logic       pend_ld;
  logic       fetch_vld_nxt;

  // Wraps modulo 2^32 by construction of the 32-bit add.
  assign pc4 = pc + 32'd4;

  pc_sequencer_nextpc u_nextpc (
    .pc4      (pc4),
    .exc_req  (exc_req),
    .exc_vec  (EXC_VEC),
    .eret     (eret),
    .epc      (epc),
    .br_taken (br_taken),
    .br_addr  (br_addr),
    .jump     (jump),
    .j_addr   (j_addr),
    .jump_r   (jump_r),
    .jr_addr  (jr_addr),
    .src      (npc_src),
    .target   (npc_tgt)
  );

  always_comb begin
    state_nxt     = state;
    pc_nxt        = pc;
    pend_vld_nxt  = pend_vld;
    pend_ld       = 1'b0;
    fetch_vld_nxt = 1'b0;
    case (state)
      PCS_HOLD: begin
        // Bubble after reset: pc stays at RESET_PC, requests are not taken.
        state_nxt = PCS_RUN;
      end
      default: begin
        // RUN and EXC share redirect handling; EXC only differs in that it
        // lasts one cycle unless another exception arrives.
        state_nxt     = PCS_RUN;
        fetch_vld_nxt = ~stall;
        if (npc_src == SRC_EXC) begin
          pc_nxt        = npc_tgt;
          pend_vld_nxt  = 1'b0;
          state_nxt     = PCS_EXC;
          fetch_vld_nxt = 1'b0;
        end else if (is_cp0_redirect(npc_src)) begin
          pc_nxt       = npc_tgt;
          pend_vld_nxt = 1'b0;
        end else if (stall) begin
          // Highest-priority ID redirect this cycle overwrites any older entry.
          if (is_ctl_redirect(npc_src)) begin
            pend_ld      = 1'b1;
            pend_vld_nxt = 1'b1;
          end
        end else if (is_ctl_redirect(npc_src)) begin
          // A fresh redirect supersedes the buffered one.
          pc_nxt       = npc_tgt;
          pend_vld_nxt = 1'b0;
        end else if (pend_vld) begin
          pc_nxt       = pend_addr;
          pend_vld_nxt = 1'b0;
        end else begin
          pc_nxt = npc_tgt;
        end
      end
    endcase
  end

  // ---- register stage: control and PC ----
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= PCS_HOLD;
      pc        <= RESET_PC;
      fetch_vld <= 1'b0;
      pc_misal  <= 1'b0;
      pend_vld  <= 1'b0;
    end else begin
      state     <= state_nxt;
      pc        <= pc_nxt;
      fetch_vld <= fetch_vld_nxt;
      pc_misal  <= word_misal(pc_nxt);
      pend_vld  <= pend_vld_nxt;
    end
  end

  // Pending target is qualified by pend_vld, so it needs no reset.
  always_ff @(posedge clk) begin
    if (pend_ld) begin
      pend_addr <= npc_tgt;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;
  import pc_sequencer_pkg::*;

  logic  clk = 1'b0;
  logic  reset_n;
  logic  stall, br_taken, jump, jump_r, exc_req, eret;
  word_t br_addr, j_addr, jr_addr, epc;
  word_t pc, pc4;
  logic  fetch_vld, pc_misal, pend_vld;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    word_t pc;
    logic  fv;
    logic  mis;
    logic  pend;
  } exp_t;

  exp_t  exp_q[$];
  string tag_q[$];
  exp_t  mon_e;
  string mon_t;

  // flag bits: {stall, br_taken, jump, jump_r, exc_req, eret}
  localparam logic [5:0] F_NONE = 6'b000000;
  localparam logic [5:0] F_ST   = 6'b100000;
  localparam logic [5:0] F_BR   = 6'b010000;
  localparam logic [5:0] F_J    = 6'b001000;
  localparam logic [5:0] F_JR   = 6'b000100;
  localparam logic [5:0] F_EXC  = 6'b000010;
  localparam logic [5:0] F_ERET = 6'b000001;

  pc_sequencer dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .stall     (stall),
    .br_taken  (br_taken),
    .br_addr   (br_addr),
    .jump      (jump),
    .j_addr    (j_addr),
    .jump_r    (jump_r),
    .jr_addr   (jr_addr),
    .exc_req   (exc_req),
    .eret      (eret),
    .epc       (epc),
    .pc        (pc),
    .pc4       (pc4),
    .fetch_vld (fetch_vld),
    .pc_misal  (pc_misal),
    .pend_vld  (pend_vld)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input string fld, input word_t got, input word_t want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s.%s: got %h, expected %h", tag, fld, got, want);
    end
  endtask

  // Drive one cycle of inputs at a negedge and queue the state expected
  // after the following posedge.
  task automatic cyc(input string tag, input logic [5:0] f,
                     input word_t ba, input word_t ja, input word_t jra, input word_t ep,
                     input word_t xpc, input logic xfv, input logic xmis, input logic xpend);
    exp_t e;
    {stall, br_taken, jump, jump_r, exc_req, eret} = f;
    br_addr = ba;
    j_addr  = ja;
    jr_addr = jra;
    epc     = ep;
    e.pc   = xpc;
    e.fv   = xfv;
    e.mis  = xmis;
    e.pend = xpend;
    exp_q.push_back(e);
    tag_q.push_back(tag);
    @(negedge clk);
  endtask

  task automatic idle(input string tag, input word_t xpc, input logic xfv, input logic xmis);
    cyc(tag, F_NONE, '0, '0, '0, '0, xpc, xfv, xmis, 1'b0);
  endtask

  // Monitor: compares the DUT against the oldest queued expectation.
  always @(posedge clk) begin
    #1;
    if (exp_q.size() != 0) begin
      mon_e = exp_q.pop_front();
      mon_t = tag_q.pop_front();
      chk(mon_t, "pc",        pc,                 mon_e.pc);
      chk(mon_t, "pc4",       pc4,                mon_e.pc + 32'd4);
      chk(mon_t, "fetch_vld", {31'd0, fetch_vld}, {31'd0, mon_e.fv});
      chk(mon_t, "pc_misal",  {31'd0, pc_misal},  {31'd0, mon_e.mis});
      chk(mon_t, "pend_vld",  {31'd0, pend_vld},  {31'd0, mon_e.pend});
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset_n = 1'b0;
    {stall, br_taken, jump, jump_r, exc_req, eret} = F_NONE;
    br_addr = '0; j_addr = '0; jr_addr = '0; epc = '0;

    #12;
    chk("rst", "pc",        pc,                 32'h0000_3000);
    chk("rst", "pc4",       pc4,                32'h0000_3004);
    chk("rst", "fetch_vld", {31'd0, fetch_vld}, 32'd0);
    chk("rst", "pc_misal",  {31'd0, pc_misal},  32'd0);
    chk("rst", "pend_vld",  {31'd0, pend_vld},  32'd0);

    // 1. reset release, idle
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    chk("rel", "pc",        pc,                 32'h0000_3000);
    chk("rel", "fetch_vld", {31'd0, fetch_vld}, 32'd0);
    idle("t1_hold", 32'h0000_3000, 1'b0, 1'b0);
    idle("t1_seq0", 32'h0000_3004, 1'b1, 1'b0);
    idle("t1_seq1", 32'h0000_3008, 1'b1, 1'b0);
    idle("t1_seq2", 32'h0000_300C, 1'b1, 1'b0);
    idle("t1_seq3", 32'h0000_3010, 1'b1, 1'b0);

    // 2. branch beats simultaneous jump
    cyc("t2_br", F_BR | F_J, 32'h0000_3100, 32'h0000_3200, '0, '0,
        32'h0000_3100, 1'b1, 1'b0, 1'b0);
    cyc("t2_j", F_J, '0, 32'h0000_3020, '0, '0,
        32'h0000_3020, 1'b1, 1'b0, 1'b0);

    // 3. jr during stall is buffered, applied after stall drops
    cyc("t3_st0", F_ST | F_JR, '0, '0, 32'h0000_3400, '0,
        32'h0000_3020, 1'b0, 1'b0, 1'b1);
    cyc("t3_st1", F_ST, '0, '0, '0, '0, 32'h0000_3020, 1'b0, 1'b0, 1'b1);
    cyc("t3_st2", F_ST, '0, '0, '0, '0, 32'h0000_3020, 1'b0, 1'b0, 1'b1);
    idle("t3_apply", 32'h0000_3400, 1'b1, 1'b0);

    // later request overwrites pending entry
    cyc("t3_ow0", F_ST | F_BR, 32'h0000_3500, '0, '0, '0,
        32'h0000_3400, 1'b0, 1'b0, 1'b1);
    cyc("t3_ow1", F_ST | F_J, '0, 32'h0000_3600, '0, '0,
        32'h0000_3400, 1'b0, 1'b0, 1'b1);
    idle("t3_ow_apply", 32'h0000_3600, 1'b1, 1'b0);

    // new request on the first unstalled cycle wins over pending
    cyc("t3_nw0", F_ST | F_BR, 32'h0000_3800, '0, '0, '0,
        32'h0000_3600, 1'b0, 1'b0, 1'b1);
    cyc("t3_nw1", F_JR, '0, '0, 32'h0000_3900, '0,
        32'h0000_3900, 1'b1, 1'b0, 1'b0);
    idle("t3_nw2", 32'h0000_3904, 1'b1, 1'b0);

    // 4. exception under stall with pending, eret dropped
    cyc("t4_pend", F_ST | F_BR, 32'h0000_3400, '0, '0, '0,
        32'h0000_3904, 1'b0, 1'b0, 1'b1);
    cyc("t4_exc", F_ST | F_EXC | F_ERET, '0, '0, '0, 32'h0000_5000,
        32'h0000_4180, 1'b0, 1'b0, 1'b0);
    idle("t4_run", 32'h0000_4184, 1'b1, 1'b0);
    cyc("t4_exc2a", F_EXC, '0, '0, '0, '0, 32'h0000_4180, 1'b0, 1'b0, 1'b0);
    cyc("t4_exc2b", F_EXC, '0, '0, '0, '0, 32'h0000_4180, 1'b0, 1'b0, 1'b0);
    idle("t4_run2", 32'h0000_4184, 1'b1, 1'b0);

    // 5. eret to misaligned epc, then wrap at top of address space
    cyc("t5_eret", F_ERET, '0, '0, '0, 32'h0000_3002,
        32'h0000_3002, 1'b1, 1'b1, 1'b0);
    idle("t5_mis_seq", 32'h0000_3006, 1'b1, 1'b1);
    cyc("t5_top", F_J, '0, 32'hFFFF_FFFC, '0, '0,
        32'hFFFF_FFFC, 1'b1, 1'b0, 1'b0);
    idle("t5_wrap", 32'h0000_0000, 1'b1, 1'b0);

    // 6. async reset while in EXC
    cyc("t6_exc", F_EXC, '0, '0, '0, '0, 32'h0000_4180, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    reset_n = 1'b0;
    #1;
    chk("t6_async", "pc",        pc,                 32'h0000_3000);
    chk("t6_async", "fetch_vld", {31'd0, fetch_vld}, 32'd0);
    chk("t6_async", "pend_vld",  {31'd0, pend_vld},  32'd0);
    chk("t6_async", "pc_misal",  {31'd0, pc_misal},  32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    idle("t6_hold", 32'h0000_3000, 1'b0, 1'b0);
    idle("t6_seq",  32'h0000_3004, 1'b1, 1'b0);

    @(posedge clk);
    #2;
    chk("drain", "queue", exp_q.size(), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
